intf_bus_master: RTL and testbench
==================================

Name: intf_bus_master

Overview:
- RTL initiator for the 8-bit read/enable/addr/data bus; drives the same signal set the tb modport drives.
- Lets synthesizable logic, not only the testbench, read any responder attached through the dut modport.
- Accepts a burst-read command, issues one bus beat per address with credit-based flow control, and returns data on a buffered valid/ready response stream.

Parameters:
ADDR_W, 8, width of bus_addr, cmd_addr and cmd_len
DATA_W, 8, width of bus_data and rsp_data
RD_LAT, 1, edges from the responder sampling a beat to bus_data valid for that beat; range 1..4
FIFO_DEPTH, 4, response buffer entries; power of 2 and at least RD_LAT+1

Ports:
clk  input  1  bus clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted at an edge where cmd_valid & cmd_ready
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  ADDR_W  beats minus one (0 = 1 beat, 255 = 256 beats)
bus_enable  output  ADDR_W-independent 1  beat strobe to responder
bus_read  output  1  read qualifier; equals bus_enable
bus_addr  output  ADDR_W  beat address
bus_data  input  DATA_W  responder read data
rsp_valid  output  1  response word available
rsp_ready  input  1  consumer accepts the word at an edge where rsp_valid & rsp_ready
rsp_data  output  DATA_W  read data, in issue order
rsp_last  output  1  marks the final beat of a burst
busy  output  1  high in ISSUE or DRAIN

Behaviour:
- Reset (async assert, sync release): state IDLE; FIFO and delay line cleared. Output values in reset:
  - cmd_ready=0, bus_enable=0, bus_read=0, bus_addr=0
  - rsp_valid=0, rsp_data=0, rsp_last=0, busy=0
  - cmd_ready rises at the first edge after reset release.
- All outputs are registered.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, latch addr=cmd_addr and remaining=cmd_len+1 (ADDR_W+1 bits), drop cmd_ready, go to ISSUE.
  - ISSUE: at each edge, issue a beat if remaining>0 and fifo_count+inflight < FIFO_DEPTH. Issuing a beat means:
    - bus_enable=bus_read=1 and bus_addr=addr for the following cycle;
    - addr increments modulo 2^ADDR_W (0xFF wraps to 0x00);
    - remaining decrements;
    - inflight increments.
  - ISSUE, no beat issued: bus_enable=bus_read=0; bus_addr holds its value.
  - ISSUE exit: when the last beat is issued, go to DRAIN.
  - DRAIN: no new beats. When inflight==0, FIFO empty and the last word has been popped, go to IDLE; cmd_ready=1 at that edge.
- Accept timing: bus_enable is high in the cycle immediately after the accept edge, with bus_addr=cmd_addr. Back-to-back beats are issued while credit allows.
- Read path: the responder samples the beat at edge E. The master captures bus_data into the FIFO at edge E+RD_LAT.
  - An RD_LAT-deep shift register carries {valid,last} per beat; last is set on the beat issued with remaining==1.
  - Capture decrements inflight.
- Latency:
  - RD_LAT=1: first rsp_valid two cycles after the accept edge.
  - General: 1+RD_LAT cycles after the accept edge.
- Credit: a pop in the same cycle is not credited until the next edge (conservative). The FIFO therefore never overflows, and bus_data is never dropped regardless of rsp_ready.
- Simultaneous push and pop: both happen and fifo_count is unchanged.
- FIFO empty: rsp_valid=0; rsp_data and rsp_last hold their last values.
- rsp_last is high only with the final word of each burst.
- cmd_valid outside IDLE is ignored: no accept, and it has no effect on the current burst.
- Reset mid-burst: the burst is aborted immediately and buffered or in-flight data is discarded. No rsp_valid appears for the aborted burst after reset release.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs zero asynchronously; cmd_ready=1 at the first edge after release.
- Single beat, RD_LAT=1, responder returns addr^0xA5: cmd_addr=0x10, len=0 -> one enable cycle with addr 0x10; rsp_data=0xB5, rsp_last=1, rsp_valid two cycles after accept; back to IDLE after pop.
- Wrap burst: cmd_addr=0xFE, len=3, rsp_ready=1 -> bus_addr sequence FE,FF,00,01 on consecutive cycles; rsp_data 5B,5A,A5,A4; rsp_last only on A4.
- Backpressure: len=15, rsp_ready=0 -> exactly 4 beats issued (addrs 0..3), then bus_enable=0. Release rsp_ready -> all 16 words in order, no loss or duplication, 16 enable cycles total.
- Busy command: second cmd_valid held during a burst -> cmd_ready=0 until the first burst's last word is popped; the second command is accepted at the IDLE edge.
- RD_LAT=3, FIFO_DEPTH=4, reset asserted after 2 beats issued -> no rsp_valid after release; a new len=1 burst completes correctly with first rsp_valid 4 cycles after accept.

Source files
------------

// File: rtl/intf_bus_master_if.sv
// Bundle of command, bus-beat and response signals around the burst-read master.
interface intf_bus_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic              bus_enable;
    logic              bus_read;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, bus_data, rsp_ready,
        output cmd_ready, bus_enable, bus_read, bus_addr, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, bus_data, rsp_ready,
        input  cmd_ready, bus_enable, bus_read, bus_addr, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/intf_bus_master.sv
// Burst-read initiator: issues credit-limited bus beats and buffers the returned
// data onto a registered valid/ready response stream.
module intf_bus_master #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    intf_bus_master_if.master bus,
    output logic              busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned REM_W = ADDR_W + 1;
    localparam int unsigned ENT_W = DATA_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [REM_W-1:0]  remaining;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              beat_last;
    logic [RD_LAT-1:0] dl_vld;
    logic [RD_LAT-1:0] dl_last;
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];

    logic              accept;
    logic              issue;
    logic              issue_last;
    logic [ADDR_W-1:0] issue_addr;
    logic              credit;
    logic              push;
    logic              push_last;
    logic              pop;
    logic [CNT_W-1:0]  count_kept;
    logic [CNT_W-1:0]  count_n;
    logic [PTR_W-1:0]  rd_ptr_n;

    // Credit ignores a same-cycle pop, so buffered plus in-flight never exceeds the FIFO.
    assign credit     = ({1'b0, count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign accept     = (state == IDLE) & bus.cmd_ready & bus.cmd_valid;
    assign issue      = accept | ((state == ISSUE) & (remaining != '0) & credit);
    assign issue_last = (state == IDLE) ? (bus.cmd_len == '0) : (remaining == REM_W'(1));
    assign issue_addr = (state == IDLE) ? bus.cmd_addr : addr;
    assign push       = dl_vld[RD_LAT-1];
    assign push_last  = dl_last[RD_LAT-1];
    assign pop        = bus.rsp_valid & bus.rsp_ready;
    assign count_kept = count - CNT_W'(pop);
    assign count_n    = count_kept + CNT_W'(push);
    assign rd_ptr_n   = rd_ptr + PTR_W'(pop);

    // Per-beat {valid,last} tracker aligned to the responder's read latency.
    if (RD_LAT > 1) begin : g_dl
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dl_vld  <= '0;
                dl_last <= '0;
            end else begin
                dl_vld  <= {dl_vld[RD_LAT-2:0], bus.bus_enable};
                dl_last <= {dl_last[RD_LAT-2:0], beat_last};
            end
        end
    end else begin : g_dl1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dl_vld  <= '0;
                dl_last <= '0;
            end else begin
                dl_vld  <= bus.bus_enable;
                dl_last <= beat_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_last, bus.bus_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            remaining      <= '0;
            inflight       <= '0;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            beat_last      <= 1'b0;
            bus.cmd_ready  <= 1'b0;
            bus.bus_enable <= 1'b0;
            bus.bus_read   <= 1'b0;
            bus.bus_addr   <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_last   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            bus.bus_enable <= issue;
            bus.bus_read   <= issue;
            beat_last      <= issue & issue_last;
            if (issue) begin
                bus.bus_addr <= issue_addr;
            end
            inflight <= inflight - CNT_W'(push) + CNT_W'(issue);

            // The FIFO head is mirrored into the rsp_* registers as it changes.
            count  <= count_n;
            rd_ptr <= rd_ptr_n;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (count_n != '0) begin
                bus.rsp_valid <= 1'b1;
                if (count_kept == '0) begin
                    {bus.rsp_last, bus.rsp_data} <= {push_last, bus.bus_data};
                end else begin
                    {bus.rsp_last, bus.rsp_data} <= mem[rd_ptr_n];
                end
            end else begin
                bus.rsp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.cmd_ready <= 1'b0;
                        addr          <= issue_addr + ADDR_W'(1);
                        remaining     <= REM_W'(bus.cmd_len);
                        state         <= (bus.cmd_len == '0) ? DRAIN : ISSUE;
                        busy          <= 1'b1;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - REM_W'(1);
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && (count_n == '0)) begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intf_bus_master.sv
// Directed bench for intf_bus_master with RD_LAT=1 and RD_LAT=3 instances and
// addr^0xA5 responders.
module tb_intf_bus_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       busy1;
    logic       busy3;
    logic [7:0] p3a;
    logic [7:0] p3b;
    int         checks = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    intf_bus_master_if #(.ADDR_W(8), .DATA_W(8)) i1 ();
    intf_bus_master_if #(.ADDR_W(8), .DATA_W(8)) i3 ();

    intf_bus_master #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .bus(i1.master), .busy(busy1));
    intf_bus_master #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .bus(i3.master), .busy(busy3));

    // Responders return addr^0xA5, RD_LAT edges after sampling the beat.
    always @(posedge clk) begin
        i1.bus_data <= i1.bus_addr ^ 8'hA5;
        p3a         <= i3.bus_addr ^ 8'hA5;
        p3b         <= p3a;
        i3.bus_data <= p3b;
    end

    function automatic logic [21:0] outs1();
        return {i1.cmd_ready, i1.bus_enable, i1.bus_read, i1.bus_addr,
                i1.rsp_valid, i1.rsp_data, i1.rsp_last, busy1};
    endfunction

    function automatic logic [21:0] outs3();
        return {i3.cmd_ready, i3.bus_enable, i3.bus_read, i3.bus_addr,
                i3.rsp_valid, i3.rsp_data, i3.rsp_last, busy3};
    endfunction

    task automatic wait_idle(input bit which);
        for (int c = 0; c < 60; c++) begin
            if ((which ? i3.cmd_ready : i1.cmd_ready) === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [21:0] v;
        bit seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        v = outs1();
        checks++;
        if (v !== 22'h0) begin fails++; $display("FAIL reset_outputs: got %h expected 000000", v); end
        rst = 1'b0;
        #1;
        checks++;
        if (i1.cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_at_release: got %b expected 0", i1.cmd_ready); end
        @(negedge clk);
        checks++;
        if ({i1.cmd_ready, i3.cmd_ready} !== 2'b11) begin
            fails++; $display("FAIL ready_first_edge: got %b expected 11", {i1.cmd_ready, i3.cmd_ready});
        end
        i1.cmd_addr = 8'h20; i1.cmd_len = 8'h03; i1.cmd_valid = 1'b1;
        @(negedge clk);
        i1.cmd_valid = 1'b0;
        checks++;
        if (i1.bus_enable !== 1'b1) begin fails++; $display("FAIL pre_reset_enable: got %b expected 1", i1.bus_enable); end
        #2 rst = 1'b1;
        #1;
        v = outs1();
        checks++;
        if (v !== 22'h0) begin fails++; $display("FAIL async_reset_outputs: got %h expected 000000", v); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (i1.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL aborted_rsp_valid: got %b expected 0", seen); end
    endtask

    task automatic test_single;
        wait_idle(1'b0);
        i1.cmd_addr = 8'h10; i1.cmd_len = 8'h00; i1.rsp_ready = 1'b0; i1.cmd_valid = 1'b1;
        @(negedge clk);
        i1.cmd_valid = 1'b0;
        checks++;
        if ({i1.cmd_ready, i1.bus_enable, i1.bus_read, i1.bus_addr, busy1} !== {3'b011, 8'h10, 1'b1}) begin
            fails++; $display("FAIL single_issue: got %b_%b%b_%h_%b expected 0_11_10_1",
                i1.cmd_ready, i1.bus_enable, i1.bus_read, i1.bus_addr, busy1);
        end
        @(negedge clk);
        checks++;
        if ({i1.bus_enable, i1.bus_addr, i1.rsp_valid} !== {1'b0, 8'h10, 1'b0}) begin
            fails++; $display("FAIL single_gap: got en=%b addr=%h vld=%b expected 0 10 0",
                i1.bus_enable, i1.bus_addr, i1.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({i1.rsp_valid, i1.rsp_data, i1.rsp_last} !== {1'b1, 8'hB5, 1'b1}) begin
            fails++; $display("FAIL single_rsp: got vld=%b data=%h last=%b expected 1 b5 1",
                i1.rsp_valid, i1.rsp_data, i1.rsp_last);
        end
        i1.rsp_ready = 1'b1;
        @(negedge clk);
        i1.rsp_ready = 1'b0;
        checks++;
        if ({i1.rsp_valid, i1.rsp_data, i1.cmd_ready, busy1} !== {1'b0, 8'hB5, 2'b10}) begin
            fails++; $display("FAIL single_done: got vld=%b data=%h rdy=%b busy=%b expected 0 b5 1 0",
                i1.rsp_valid, i1.rsp_data, i1.cmd_ready, busy1);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_a [4];
        logic [7:0] exp_d [4];
        logic [7:0] got_a [4];
        logic [7:0] got_d [4];
        logic       got_l [4];
        int na, nd, first_c, last_c;
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_d = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
        na = 0; nd = 0; first_c = -1; last_c = -1;
        wait_idle(1'b0);
        i1.cmd_addr = 8'hFE; i1.cmd_len = 8'h03; i1.rsp_ready = 1'b1; i1.cmd_valid = 1'b1;
        @(negedge clk);
        i1.cmd_valid = 1'b0;
        for (int c = 0; c < 30 && nd < 4; c++) begin
            if (i1.bus_enable === 1'b1) begin
                if (na < 4) got_a[na] = i1.bus_addr;
                na++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (i1.rsp_valid === 1'b1) begin
                if (nd < 4) begin got_d[nd] = i1.rsp_data; got_l[nd] = i1.rsp_last; end
                nd++;
            end
            @(negedge clk);
        end
        i1.rsp_ready = 1'b0;
        checks++;
        if (na !== 4 || nd !== 4) begin fails++; $display("FAIL wrap_counts: got beats=%0d words=%0d expected 4 4", na, nd); end
        checks++;
        if (last_c - first_c !== 3) begin fails++; $display("FAIL wrap_consecutive: got span %0d expected 3", last_c - first_c); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin fails++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, got_a[i], exp_a[i]); end
            checks++;
            if ({got_l[i], got_d[i]} !== {(i == 3), exp_d[i]}) begin
                fails++; $display("FAIL wrap_rsp[%0d]: got last=%b data=%h expected %b %h", i, got_l[i], got_d[i], (i == 3), exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] got_a [4];
        int na, nd;
        na = 0; nd = 0;
        wait_idle(1'b0);
        i1.cmd_addr = 8'h00; i1.cmd_len = 8'h0F; i1.rsp_ready = 1'b0; i1.cmd_valid = 1'b1;
        @(negedge clk);
        i1.cmd_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (i1.bus_enable === 1'b1) begin
                if (na < 4) got_a[na] = i1.bus_addr;
                na++;
            end
            @(negedge clk);
        end
        checks++;
        if (na !== 4) begin fails++; $display("FAIL bp_stalled_beats: got %0d expected 4", na); end
        checks++;
        if ({got_a[0], got_a[1], got_a[2], got_a[3]} !== 32'h00010203) begin
            fails++; $display("FAIL bp_addrs: got %h %h %h %h expected 00 01 02 03", got_a[0], got_a[1], got_a[2], got_a[3]);
        end
        checks++;
        if ({i1.bus_enable, i1.rsp_valid, i1.rsp_data} !== {2'b01, 8'hA5}) begin
            fails++; $display("FAIL bp_hold: got en=%b vld=%b data=%h expected 0 1 a5", i1.bus_enable, i1.rsp_valid, i1.rsp_data);
        end
        i1.rsp_ready = 1'b1;
        for (int c = 0; c < 100 && nd < 16; c++) begin
            if (i1.bus_enable === 1'b1) na++;
            if (i1.rsp_valid === 1'b1) begin
                checks++;
                if ({i1.rsp_last, i1.rsp_data} !== {(nd == 15), 8'(nd) ^ 8'hA5}) begin
                    fails++; $display("FAIL bp_word[%0d]: got last=%b data=%h expected %b %h",
                        nd, i1.rsp_last, i1.rsp_data, (nd == 15), 8'(nd) ^ 8'hA5);
                end
                nd++;
            end
            @(negedge clk);
        end
        i1.rsp_ready = 1'b0;
        checks++;
        if (nd !== 16 || na !== 16) begin fails++; $display("FAIL bp_totals: got words=%0d beats=%0d expected 16 16", nd, na); end
        checks++;
        if ({i1.rsp_valid, i1.cmd_ready} !== 2'b01) begin
            fails++; $display("FAIL bp_end: got vld=%b rdy=%b expected 0 1", i1.rsp_valid, i1.cmd_ready);
        end
    endtask

    task automatic test_busy_cmd;
        logic [7:0] got_d [2];
        logic       got_l [2];
        bit premature;
        int last_seen, ready_c, nd;
        bit got2;
        premature = 1'b0; last_seen = -1; ready_c = -1; nd = 0; got2 = 1'b0;
        wait_idle(1'b0);
        i1.cmd_addr = 8'h40; i1.cmd_len = 8'h01; i1.rsp_ready = 1'b1; i1.cmd_valid = 1'b1;
        @(negedge clk);
        i1.cmd_addr = 8'h80; i1.cmd_len = 8'h00;
        for (int c = 0; c < 30; c++) begin
            if (i1.cmd_ready === 1'b1) begin
                if (last_seen < 0) premature = 1'b1;
                else begin ready_c = c; break; end
            end
            if (i1.rsp_valid === 1'b1) begin
                if (nd < 2) begin got_d[nd] = i1.rsp_data; got_l[nd] = i1.rsp_last; end
                nd++;
                if (i1.rsp_last === 1'b1) last_seen = c;
            end
            @(negedge clk);
        end
        @(negedge clk);
        i1.cmd_valid = 1'b0;
        checks++;
        if (premature !== 1'b0) begin fails++; $display("FAIL busy_premature_ready: got %b expected 0", premature); end
        checks++;
        if (ready_c - last_seen !== 1) begin fails++; $display("FAIL busy_ready_timing: got %0d expected 1", ready_c - last_seen); end
        checks++;
        if (nd !== 2 || {got_l[0], got_d[0], got_l[1], got_d[1]} !== {1'b0, 8'hE5, 1'b1, 8'hE4}) begin
            fails++; $display("FAIL busy_first_burst: got n=%0d %b%h %b%h expected 2 0e5 1e4", nd, got_l[0], got_d[0], got_l[1], got_d[1]);
        end
        checks++;
        if ({i1.bus_enable, i1.bus_addr, i1.cmd_ready} !== {1'b1, 8'h80, 1'b0}) begin
            fails++; $display("FAIL busy_second_accept: got en=%b addr=%h rdy=%b expected 1 80 0", i1.bus_enable, i1.bus_addr, i1.cmd_ready);
        end
        for (int c = 0; c < 20 && !got2; c++) begin
            @(negedge clk);
            if (i1.rsp_valid === 1'b1) begin
                got2 = 1'b1;
                checks++;
                if ({i1.rsp_last, i1.rsp_data} !== {1'b1, 8'h25}) begin
                    fails++; $display("FAIL busy_second_rsp: got last=%b data=%h expected 1 25", i1.rsp_last, i1.rsp_data);
                end
            end
        end
        checks++;
        if (got2 !== 1'b1) begin fails++; $display("FAIL busy_second_timeout: got %b expected 1", got2); end
        @(negedge clk);
        i1.rsp_ready = 1'b0;
    endtask

    task automatic test_lat3;
        logic [21:0] v;
        logic [7:0]  got_d [2];
        logic        got_l [2];
        bit seen;
        int first, nd;
        first = -1; nd = 0;
        wait_idle(1'b1);
        i3.cmd_addr = 8'h30; i3.cmd_len = 8'h07; i3.rsp_ready = 1'b0; i3.cmd_valid = 1'b1;
        @(negedge clk);
        i3.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({i3.bus_enable, i3.bus_addr} !== {1'b1, 8'h31}) begin
            fails++; $display("FAIL lat3_second_beat: got en=%b addr=%h expected 1 31", i3.bus_enable, i3.bus_addr);
        end
        #2 rst = 1'b1;
        #1;
        v = outs3();
        checks++;
        if (v !== 22'h0) begin fails++; $display("FAIL lat3_reset_outputs: got %h expected 000000", v); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (i3.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if ({seen, i3.cmd_ready} !== 2'b01) begin
            fails++; $display("FAIL lat3_post_reset: got seen=%b rdy=%b expected 0 1", seen, i3.cmd_ready);
        end
        i3.cmd_addr = 8'h70; i3.cmd_len = 8'h01; i3.rsp_ready = 1'b1; i3.cmd_valid = 1'b1;
        @(negedge clk);
        i3.cmd_valid = 1'b0;
        for (int c = 0; c < 20 && nd < 2; c++) begin
            if (i3.rsp_valid === 1'b1) begin
                if (first < 0) first = c;
                got_d[nd] = i3.rsp_data; got_l[nd] = i3.rsp_last;
                nd++;
            end
            @(negedge clk);
        end
        i3.rsp_ready = 1'b0;
        checks++;
        if (first !== 4) begin fails++; $display("FAIL lat3_latency: got %0d expected 4", first); end
        checks++;
        if (nd !== 2 || {got_l[0], got_d[0], got_l[1], got_d[1]} !== {1'b0, 8'hD5, 1'b1, 8'hD4}) begin
            fails++; $display("FAIL lat3_words: got n=%0d %b%h %b%h expected 2 0d5 1d4", nd, got_l[0], got_d[0], got_l[1], got_d[1]);
        end
        wait_idle(1'b1);
        checks++;
        if ({i3.cmd_ready, busy3} !== 2'b10) begin
            fails++; $display("FAIL lat3_idle: got rdy=%b busy=%b expected 1 0", i3.cmd_ready, busy3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i1.cmd_valid = 1'b0; i1.cmd_addr = 8'h00; i1.cmd_len = 8'h00; i1.rsp_ready = 1'b0;
        i3.cmd_valid = 1'b0; i3.cmd_addr = 8'h00; i3.cmd_len = 8'h00; i3.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_busy_cmd();
        test_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
